// File: rtl/spi_packet_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_packet_slave
// Purpose  : SPI mode-0 slave. Receives one meta/prefix/data packet per
//            chip-select frame and shifts a queued reply out on miso.
//            Define SPI_PKT_CRC8_EN to append/check a CRC-8 trailer byte.
// Revision : 1.0  initial release
// ============================================================================
module spi_packet_slave #(
  parameter int META_W      = 8,
  parameter int PREFIX_W    = 64,
  parameter int DATA_W      = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                cs,
  output logic                miso,
  output logic                RX_valid,
  output logic [META_W-1:0]   packet_meta_data,
  output logic [PREFIX_W-1:0] packet_prefix,
  output logic [DATA_W-1:0]   packet_data,
  input  logic                TX_valid,
  input  logic [META_W-1:0]   packet_meta_data_input,
  input  logic [PREFIX_W-1:0] packet_prefix_input,
  input  logic [DATA_W-1:0]   packet_data_input,
  output logic                tx_pending,
  output logic                frame_err,
  output logic                crc_err
);

  localparam int F = META_W + PREFIX_W + DATA_W;
`ifdef SPI_PKT_CRC8_EN
  localparam int CRC_W = 8;
`else
  localparam int CRC_W = 0;
`endif
  localparam int FT = F + CRC_W;
  localparam int CW = $clog2(FT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [CW-1:0]          cnt;
  logic [FT-2:0]          rx_sr;
  logic [FT-1:0]          rx_next;
  logic [FT-1:0]          tx_sr;
  logic [FT-1:0]          tx_load;
  logic [F-1:0]           hold;
  logic                   start_pend;
  logic                   start, finish, abort;
  logic                   rx_ok;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // cs synchroniser resets to its idle (high) level so release is edge-free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall || start_pend) state_nxt = SHIFT;
      SHIFT: begin
        if (sclk_rise && (cnt == CW'(FT - 1))) state_nxt = DONE;
        else if (cs_rise)                      state_nxt = ABORT;
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start   = (state == IDLE)  && (state_nxt == SHIFT);
  assign finish  = (state == SHIFT) && (state_nxt == DONE);
  assign abort   = (state == SHIFT) && (state_nxt == ABORT);
  assign rx_next = {rx_sr, mosi_s};
  assign miso    = (state == SHIFT) && tx_sr[FT-1];

`ifdef SPI_PKT_CRC8_EN
  logic [7:0] rx_crc, tx_crc;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    crc8_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  assign rx_ok   = (rx_next[7:0] == rx_crc);
  assign tx_load = tx_pending ? {hold, 8'h00} : '0;
`else
  assign rx_ok   = 1'b1;
  assign tx_load = tx_pending ? hold : '0;
  assign crc_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      rx_sr            <= '0;
      tx_sr            <= '0;
      hold             <= '0;
      tx_pending       <= 1'b0;
      start_pend       <= 1'b0;
      RX_valid         <= 1'b0;
      frame_err        <= 1'b0;
      packet_meta_data <= '0;
      packet_prefix    <= '0;
      packet_data      <= '0;
`ifdef SPI_PKT_CRC8_EN
      rx_crc           <= '0;
      tx_crc           <= '0;
      crc_err          <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      RX_valid  <= finish && rx_ok;
      frame_err <= abort || (finish && !rx_ok);
`ifdef SPI_PKT_CRC8_EN
      crc_err   <= finish && !rx_ok;
`endif

      if (TX_valid) begin
        hold       <= {packet_meta_data_input, packet_prefix_input, packet_data_input};
        tx_pending <= 1'b1;
      end else if (start) begin
        tx_pending <= 1'b0;
      end

      // a new frame may begin while DONE/ABORT is still being retired
      if (state == IDLE)
        start_pend <= 1'b0;
      else if ((state == DONE || state == ABORT) && cs_fall)
        start_pend <= 1'b1;

      if (start) begin
        cnt   <= '0;
        tx_sr <= tx_load;
`ifdef SPI_PKT_CRC8_EN
        rx_crc <= '0;
        tx_crc <= '0;
`endif
      end

      if (state == SHIFT) begin
        if (sclk_rise) begin
          rx_sr <= rx_next[FT-2:0];
          cnt   <= cnt + 1'b1;
`ifdef SPI_PKT_CRC8_EN
          if (cnt < CW'(F)) rx_crc <= crc8_step(rx_crc, mosi_s);
`endif
        end
        if (sclk_fall) begin
`ifdef SPI_PKT_CRC8_EN
          // after the last reply bit leaves, its CRC becomes the next byte out
          if (cnt == CW'(F)) begin
            tx_sr <= {crc8_step(tx_crc, tx_sr[FT-1]), {F{1'b0}}};
          end else begin
            tx_sr <= {tx_sr[FT-2:0], 1'b0};
            if (cnt != '0) tx_crc <= crc8_step(tx_crc, tx_sr[FT-1]);
          end
`else
          tx_sr <= {tx_sr[FT-2:0], 1'b0};
`endif
        end
        if (abort) tx_sr <= '0;
      end

      if (finish && rx_ok) begin
        packet_meta_data <= rx_next[FT-1 -: META_W];
        packet_prefix    <= rx_next[FT-1-META_W -: PREFIX_W];
        packet_data      <= rx_next[CRC_W +: DATA_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_packet_slave.md
Name: spi_packet_slave

Overview:
- SPI mode-0 peripheral (slave) at the far end of the router's packet SPI link. It is the counterpart to the spi_interface master.
- Deserialises one packet per chip-select frame from mosi: meta byte, then prefix, then data, each MSB-first.
- Simultaneously serialises a locally queued reply packet onto miso.
- Oversamples sclk/cs/mosi on the system clock; all outputs are synchronous to clk.

Parameters:
- META_W, 8, packet meta-data width in bits
- PREFIX_W, 64, packet prefix width in bits
- DATA_W, 256, packet payload width in bits
- SYNC_STAGES, 2, synchroniser depth for sclk, cs, mosi (minimum 2)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- sclk  input  1  SPI clock from master, idle low
- mosi  input  1  master-out data
- cs  input  1  chip select, active low
- miso  output  1  slave-out data
- RX_valid  output  1  one-cycle pulse: packet outputs updated
- packet_meta_data  output  META_W  received meta byte
- packet_prefix  output  PREFIX_W  received prefix
- packet_data  output  DATA_W  received payload
- TX_valid  input  1  one-cycle pulse: capture reply packet
- packet_meta_data_input  input  META_W  reply meta
- packet_prefix_input  input  PREFIX_W  reply prefix
- packet_data_input  input  DATA_W  reply payload
- tx_pending  output  1  a reply is queued for the next frame
- frame_err  output  1  one-cycle pulse: frame aborted or failed check
- crc_err  output  1  one-cycle pulse: CRC mismatch (tied 0 without the optional feature)

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, bit counter 0, holding register and shift registers 0.
- Frame length: F = META_W+PREFIX_W+DATA_W (328 bits at defaults).
- Synchronisation and timing:
  - sclk, cs and mosi each pass through SYNC_STAGES flops, plus one edge-detect flop.
  - Rising and falling edges are decoded from the synchronised copies.
  - sclk must be no faster than clk/8.
- States:
  - IDLE -> SHIFT on cs falling edge.
  - SHIFT -> DONE when the bit counter reaches F.
  - SHIFT -> ABORT on cs rising edge with counter < F.
  - DONE -> IDLE after one cycle.
  - ABORT -> IDLE after one cycle.
- IDLE→SHIFT transition:
  - Counter cleared.
  - TX shift register loaded from the holding register if tx_pending=1, else all zeros.
  - tx_pending cleared in the same cycle.
  - miso drives the TX MSB in the cycle after the cs edge is detected.
- SHIFT:
  - On each sclk rising edge: shift synchronised mosi into the RX shift register LSB; counter +1.
  - On each sclk falling edge: shift the TX register left; miso = new MSB.
  - The counter width is clog2(F+1) and it does not wrap.
- DONE:
  - packet_meta_data = RX[F-1 -: META_W], packet_prefix = next PREFIX_W bits, packet_data = lowest DATA_W bits.
  - RX_valid=1 for exactly this cycle.
  - Latency: RX_valid is high the cycle after the rising edge of bit F-1 is detected.
- After DONE, while cs is still low: further sclk edges are ignored and miso=0.
- ABORT:
  - frame_err=1 for one cycle.
  - Packet outputs are unchanged and RX_valid stays 0.
  - The unsent TX reply is discarded.
- miso=0 whenever not in SHIFT. No tri-state.
- Packet outputs hold their value until the next DONE.
- TX_valid:
  - Accepted in any state; captures all three inputs into the holding register and sets tx_pending the next cycle.
  - A second TX_valid before the next frame start overwrites the queued reply (last writer wins).
  - TX_valid in the same cycle as the IDLE→SHIFT load: the old holding value is loaded into the shift register; the new value is captured and tx_pending remains 1.
- cs falling edge while in DONE or ABORT is honoured on the following IDLE cycle. The master guarantees ≥4 clk of cs high between frames.
- Async reset mid-frame: immediate return to reset values; the frame is lost with no frame_err.

Optional Feature:
- Macro: SPI_PKT_CRC8_EN.
- Defined:
  - Frame is F+8 bits; the final byte is CRC-8 (poly 0x07, init 0x00, MSB-first) over the preceding F bits.
  - RX: CRC is computed serially as bits arrive.
  - On completion with a mismatch: no RX_valid and no output update; crc_err=1 and frame_err=1 for one cycle.
  - TX: the slave appends the CRC of the reply bits it shifted out.
- Undefined: frame is F bits, no CRC logic, crc_err tied 0.

Test Plan:
- Reset release, cs high, no sclk -> all outputs 0, miso=0, state IDLE for ≥20 cycles.
- Master sends meta=8'h28, prefix=64'd129, data="here is data" (ASCII, zero-extended to 256) -> single RX_valid pulse; outputs equal those values exactly; frame_err=0.
- TX_valid with meta=8'hA5, prefix=64'hDEAD_BEEF_0000_0001, data=256'h1 before the frame, then run a frame -> miso bitstream equals 8'hA5 ‖ prefix ‖ data MSB-first; tx_pending 1→0 at frame start; next frame's miso is all zeros.
- cs raised after 100 bits -> frame_err pulse, RX_valid never asserts, packet outputs keep the previous frame's values; next full frame is received correctly.
- Two TX_valid pulses (meta 8'h11 then 8'h22) before a frame -> miso meta byte = 8'h22; 10 extra sclk cycles after bit 327 -> ignored, single RX_valid.
- With SPI_PKT_CRC8_EN: correct CRC -> RX_valid. One flipped payload bit -> crc_err and frame_err pulses, no RX_valid. miso's last byte equals CRC-8 of the reply.
